// File: rtl/rv_pkg.sv
// rv_pkg: shared rv32i fetch constants and pc_unit FSM state encoding.
package rv_pkg;
    localparam int XLEN_DEF = 32;
    localparam int INC_RV32 = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect, stall and imem fetch handshake bundle around the PC.
interface pc_unit_if #(parameter int XLEN = 32, parameter int CNT_W = 32);
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic             fetch_ready;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus_inc;
    logic             pc_valid;
    logic             trap;
    logic [XLEN-1:0]  trap_addr;
    logic [CNT_W-1:0] fetch_count;
    modport master (
        input  stall, redirect_valid, redirect_target, fetch_ready,
        output pc, pc_plus_inc, pc_valid, trap, trap_addr, fetch_count
    );
    modport slave (
        output stall, redirect_valid, redirect_target, fetch_ready,
        input  pc, pc_plus_inc, pc_valid, trap, trap_addr, fetch_count
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: parks a redirect that arrives while imem holds the current fetch.
module pc_redirect_buf #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_i,
    input  logic            clr_i,
    input  logic [XLEN-1:0] tgt_i,
    output logic            pend_o,
    output logic [XLEN-1:0] tgt_o
);
    logic            pend_q;
    logic [XLEN-1:0] tgt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else if (set_i) begin
            pend_q <= 1'b1;
            tgt_q  <= tgt_i;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end
    end
    assign pend_o = pend_q;
    assign tgt_o  = tgt_q;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: rv32i fetch program counter with stall, buffered redirects,
// misaligned-target trap state and accepted-fetch counter.
module pc_unit import rv_pkg::*; #(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VEC_DEF),
    parameter int               INC          = INC_RV32,
    parameter int               CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_unit_if.master   bus
);
    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d, trap_addr_q, trap_addr_d, pend_tgt, tgt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d, pend, valid, hold, req, redir, aligned, take, bad, step;
    pc_redirect_buf #(.XLEN(XLEN)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (hold & bus.redirect_valid),
        .clr_i  (redir),
        .tgt_i  (bus.redirect_target),
        .pend_o (pend),
        .tgt_o  (pend_tgt)
    );
    always_comb begin
        valid       = state_q == ST_RUN;
        hold        = valid & ~bus.fetch_ready;
        req         = bus.redirect_valid | pend;
        tgt         = bus.redirect_valid ? bus.redirect_target : pend_tgt;
        aligned     = (tgt & XLEN'(INC - 1)) == '0;
        redir       = ~hold & req;
        take        = redir & aligned;
        bad         = redir & ~aligned;
        step        = ~hold & ~req & ~bus.stall & (state_q == ST_RUN);
        pc_d        = take ? tgt : step ? pc_q + XLEN'(INC) : pc_q;
        state_d     = bad ? ST_TRAP : (take | state_q == ST_BOOT) ? ST_RUN : state_q;
        trap_d      = bad;
        trap_addr_d = bad ? tgt : trap_addr_q;
        cnt_d       = cnt_q + CNT_W'(valid & bus.fetch_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VECTOR;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
            cnt_q       <= cnt_d;
        end
    end
    assign bus.pc          = pc_q;
    assign bus.pc_plus_inc = pc_q + XLEN'(INC);
    assign bus.pc_valid    = valid;
    assign bus.trap        = trap_q;
    assign bus.trap_addr   = trap_addr_q;
    assign bus.fetch_count = cnt_q;
endmodule
